// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle: CPU write handshake, fill control/status and the fb_* write bus.
// The arbiter takes the slave modport; the requester/observer side takes master.
interface fb_write_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_wr_valid;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ready;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              fb_we;

  modport master (
    output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, fill_start, fill_value,
    input  cpu_wr_ready, fill_busy, fill_done, fb_addr, fb_data, fb_we
  );

  modport slave (
    input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, fill_start, fill_value,
    output cpu_wr_ready, fill_busy, fill_done, fb_addr, fb_data, fb_we
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Arbitrates CPU writes and a full-framebuffer fill onto a single registered write port,
// alternating between the two requesters whenever both are pending.
module fb_write_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FB_DEPTH = 4096
) (
  input logic             clk50,
  input logic             rst_n,
  fb_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {FIdle, FRun, FDone} fill_state_e;

  localparam logic [ADDR_W:0] LastCnt = (ADDR_W+1)'(FB_DEPTH - 1);

  fill_state_e       state_q;
  logic [ADDR_W:0]   fill_cnt_q;
  logic [DATA_W-1:0] fill_val_q;
  logic              cpu_full_q;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [DATA_W-1:0] cpu_data_q;
  logic              last_fill_q;  // 1: fill won the most recent contested cycle
  logic              rdy_en_q;     // holds ready low until the first edge after reset
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_data_q;

  logic cpu_pend, fill_pend, cpu_grant, fill_grant, cpu_ready, cpu_accept;

  always_comb begin
    cpu_pend   = cpu_full_q;
    fill_pend  = (state_q == FRun);
    cpu_grant  = cpu_pend && (!fill_pend || last_fill_q);
    fill_grant = fill_pend && !cpu_grant;
    // Independent of cpu_wr_valid so the handshake has no combinational loop.
    cpu_ready  = rdy_en_q && (!cpu_full_q || cpu_grant);
    cpu_accept = bus.cpu_wr_valid && cpu_ready;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FIdle;
      fill_cnt_q  <= '0;
      fill_val_q  <= '0;
      cpu_full_q  <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_data_q  <= '0;
      last_fill_q <= 1'b1;
      rdy_en_q    <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
    end else begin
      rdy_en_q <= 1'b1;

      if (cpu_accept) begin
        cpu_full_q <= 1'b1;
        cpu_addr_q <= bus.cpu_wr_addr;
        cpu_data_q <= bus.cpu_wr_data;
      end else if (cpu_grant) begin
        cpu_full_q <= 1'b0;
      end

      if (cpu_pend && fill_pend) begin
        last_fill_q <= fill_grant;
      end

      fb_we_q <= cpu_grant || fill_grant;
      if (cpu_grant) begin
        fb_addr_q <= cpu_addr_q;
        fb_data_q <= cpu_data_q;
      end else if (fill_grant) begin
        fb_addr_q <= fill_cnt_q[ADDR_W-1:0];
        fb_data_q <= fill_val_q;
      end

      unique case (state_q)
        FIdle: begin
          if (bus.fill_start) begin
            fill_val_q <= bus.fill_value;
            fill_cnt_q <= '0;
            state_q    <= FRun;
          end
        end
        FRun: begin
          if (fill_grant) begin
            fill_cnt_q <= fill_cnt_q + (ADDR_W+1)'(1);
            if (fill_cnt_q == LastCnt) begin
              state_q <= FDone;
            end
          end
        end
        FDone:   state_q <= FIdle;
        default: state_q <= FIdle;
      endcase
    end
  end

  assign bus.cpu_wr_ready = cpu_ready;
  assign bus.fill_busy    = (state_q == FRun);
  assign bus.fill_done    = (state_q == FDone);
  assign bus.fb_we        = fb_we_q;
  assign bus.fb_addr      = fb_addr_q;
  assign bus.fb_data      = fb_data_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a 16-cell framebuffer: a cycle table for plain CPU
// writes, then hand-written fill, contention, restart-ignore, collision and reset sequences.
module tb_fb_write_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk50 = ~clk50;

  fb_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(16)) dut (
    .clk50 (clk50),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_ready;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    int            cyc;
  } wr_t;

  vec_t vecs[9];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk50) cyc <= cyc + 1;

  // Record every framebuffer write and every fill_done pulse seen mid-cycle.
  always @(negedge clk50) begin
    if (rst_n && bus.fb_we) begin
      wr_t w;
      w.addr = bus.fb_addr;
      w.data = bus.fb_data;
      w.busy = bus.fill_busy;
      w.done = bus.fill_done;
      w.cyc  = cyc;
      wr_q.push_back(w);
    end
    if (rst_n && bus.fill_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk50);
    rst_n = 1'b1;
    tick();
  endtask

  // Uncontested fill of 16 cells; optionally re-pulse fill_start with 0xFF mid-fill.
  task automatic fill_uncontested(input logic [DW-1:0] fv, input bit inject, input string tag);
    int n, d0, busy_cnt;
    bit seen;
    wr_q.delete();
    d0 = done_cnt;
    seen = 0;
    bus.fill_start = 1'b1;
    bus.fill_value = fv;
    n = cyc;
    tick();
    bus.fill_start = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (inject && k == 4) begin
        bus.fill_start = 1'b1;
        bus.fill_value = 8'hFF;
      end else begin
        bus.fill_start = 1'b0;
        bus.fill_value = fv;
      end
      @(negedge clk50);
      if (bus.fill_done) seen = 1;
      tick();
    end
    bus.fill_start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 1);
    repeat (4) tick();
    chk({tag, "_nwrites"}, wr_q.size(), 16);
    busy_cnt = 0;
    for (int i = 0; i < wr_q.size() && i < 16; i++) begin
      chk({tag, "_addr"}, 32'(wr_q[i].addr), i);
      chk({tag, "_data"}, 32'(wr_q[i].data), 32'(fv));
      chk({tag, "_cyc"}, wr_q[i].cyc, n + 2 + i);
      chk({tag, "_done_at"}, 32'(wr_q[i].done), (i == 15) ? 1 : 0);
      if (wr_q[i].busy) busy_cnt++;
    end
    chk({tag, "_busy_cnt"}, busy_cnt, 15);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_busy_after"}, 32'(bus.fill_busy), 0);
  endtask

  initial begin
    int n, d0, done_cyc;
    bit seen, acc, hit;
    logic [AW-1:0] ea[17];
    logic [DW-1:0] ed[17];
    logic [DW-1:0] last3;

    // cycle-by-cycle CPU vectors; outputs trail the accept by two cycles
    vecs[0] = '{1'b1, 12'h123, 8'h5A, 1'b0, 12'h000, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h123, 8'h5A, 1'b1};
    vecs[3] = '{1'b1, 12'h001, 8'h11, 1'b0, 12'h123, 8'h5A, 1'b1};
    vecs[4] = '{1'b1, 12'h0FF, 8'h22, 1'b0, 12'h123, 8'h5A, 1'b1};
    vecs[5] = '{1'b1, 12'hFFF, 8'h33, 1'b1, 12'h001, 8'h11, 1'b1};
    vecs[6] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h0FF, 8'h22, 1'b1};
    vecs[7] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'hFFF, 8'h33, 1'b1};
    vecs[8] = '{1'b0, 12'h000, 8'h00, 1'b0, 12'hFFF, 8'h33, 1'b1};

    bus.cpu_wr_valid = 1'b0;
    bus.cpu_wr_addr  = '0;
    bus.cpu_wr_data  = '0;
    bus.fill_start   = 1'b0;
    bus.fill_value   = '0;

    #25;
    chk("rst_we", 32'(bus.fb_we), 0);
    chk("rst_addr", 32'(bus.fb_addr), 0);
    chk("rst_data", 32'(bus.fb_data), 0);
    chk("rst_busy", 32'(bus.fill_busy), 0);
    chk("rst_done", 32'(bus.fill_done), 0);
    chk("rst_ready", 32'(bus.cpu_wr_ready), 0);
    @(negedge clk50);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(bus.cpu_wr_ready), 0);
    tick();
    chk("ready_after_edge", 32'(bus.cpu_wr_ready), 1);

    // V1 and back-to-back CPU writes
    for (int i = 0; i < 9; i++) begin
      bus.cpu_wr_valid = vecs[i].valid;
      bus.cpu_wr_addr  = vecs[i].addr;
      bus.cpu_wr_data  = vecs[i].data;
      @(negedge clk50);
      chk($sformatf("vec%0d_we", i), 32'(bus.fb_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_addr", i), 32'(bus.fb_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_data", i), 32'(bus.fb_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_ready", i), 32'(bus.cpu_wr_ready), 32'(vecs[i].exp_ready));
      tick();
    end
    bus.cpu_wr_valid = 1'b0;
    repeat (2) tick();

    // V2 plain fill, V4 fill with an ignored restart
    fill_uncontested(8'h20, 1'b0, "v2");
    fill_uncontested(8'h44, 1'b1, "v4");

    // V3: fill under continuous CPU traffic, CPU wins the first tie
    wr_q.delete();
    seen = 0;
    done_cyc = 0;
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_addr  = 12'h100;
    bus.cpu_wr_data  = 8'h80;
    bus.fill_start   = 1'b1;
    bus.fill_value   = 8'h55;
    n = cyc;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk50);
      acc = bus.cpu_wr_valid && bus.cpu_wr_ready;
      if (bus.fill_done) begin
        seen = 1;
        done_cyc = cyc;
      end
      tick();
      bus.fill_start = 1'b0;
      if (acc) begin
        bus.cpu_wr_addr = bus.cpu_wr_addr + 12'd1;
        bus.cpu_wr_data = bus.cpu_wr_data + 8'd1;
      end
    end
    bus.cpu_wr_valid = 1'b0;
    repeat (4) tick();
    chk("v3_done_seen", 32'(seen), 1);
    chk("v3_done_in_32", 32'((done_cyc - (n + 1)) <= 32), 1);
    chk("v3_nwrites_ge32", 32'(wr_q.size() >= 32), 1);
    for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
      if (i % 2 == 0) begin
        chk("v3_cpu_addr", 32'(wr_q[i].addr), 32'h100 + i / 2);
        chk("v3_cpu_data", 32'(wr_q[i].data), 32'h80 + i / 2);
      end else begin
        chk("v3_fill_addr", 32'(wr_q[i].addr), i / 2);
        chk("v3_fill_data", 32'(wr_q[i].data), 32'h55);
      end
    end

    // V6: CPU write to cell 3 collides with the fill's cell 3; CPU wins after reset
    do_reset();
    wr_q.delete();
    seen = 0;
    bus.fill_start = 1'b1;
    bus.fill_value = 8'h66;
    n = cyc;
    tick();
    bus.fill_start = 1'b0;
    tick();
    tick();
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_addr  = 12'h003;
    bus.cpu_wr_data  = 8'hC3;
    @(negedge clk50);
    chk("v6_ready", 32'(bus.cpu_wr_ready), 1);
    tick();
    bus.cpu_wr_valid = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk50);
      if (bus.fill_done) seen = 1;
      tick();
    end
    repeat (3) tick();
    chk("v6_done_seen", 32'(seen), 1);
    for (int i = 0; i < 17; i++) begin
      if (i < 3) begin
        ea[i] = 12'(i);
        ed[i] = 8'h66;
      end else if (i == 3) begin
        ea[i] = 12'h003;
        ed[i] = 8'hC3;
      end else begin
        ea[i] = 12'(i - 1);
        ed[i] = 8'h66;
      end
    end
    chk("v6_nwrites", wr_q.size(), 17);
    for (int i = 0; i < 17 && i < wr_q.size(); i++) begin
      chk($sformatf("v6_addr%0d", i), 32'(wr_q[i].addr), 32'(ea[i]));
      chk($sformatf("v6_data%0d", i), 32'(wr_q[i].data), 32'(ed[i]));
    end
    if (wr_q.size() > 3) chk("v6_cpu_cyc", wr_q[3].cyc, n + 5);
    last3 = 8'h00;
    foreach (wr_q[i]) if (wr_q[i].addr == 12'h003) last3 = wr_q[i].data;
    chk("v6_final_cell3", 32'(last3), 32'h66);

    // V5: reset on the 5th fill write aborts the fill; a new fill restarts from 0
    wr_q.delete();
    hit = 0;
    bus.fill_start = 1'b1;
    bus.fill_value = 8'h77;
    tick();
    bus.fill_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk50);
      if (bus.fb_we && bus.fb_addr == 12'h004) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk("v5_reached_w5", 32'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("v5_we_drop", 32'(bus.fb_we), 0);
    chk("v5_busy_drop", 32'(bus.fill_busy), 0);
    chk("v5_done_low", 32'(bus.fill_done), 0);
    d0 = done_cnt;
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("v5_no_done", done_cnt - d0, 0);
    chk("v5_idle_busy", 32'(bus.fill_busy), 0);
    fill_uncontested(8'h78, 1'b0, "v5_refill");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
